ttc_tx_frame_scheduler: RTL and testbench
=========================================

// Module: ttc_tx_frame_scheduler
// PURPOSE
//  Drains the two TX frame buffers (A: bytes 0-511, B: bytes 512-1023) of the shared 1 KiB byte TX RAM into the downlink encoder.
//  Arbitrates pending CPU start flags round-robin and reads each frame's 2-byte length header.
//  Streams the payload bytes over a valid/ready interface and returns one-cycle finish pulses to the APB glue flag register.
//  Sits between the APB glue (Flag_A_Tx/Flag_B_Tx, RAM write side) and the framer/modulator.
// PARAMETERS
//  ADDR_W     10    TX RAM byte-address width
//  BUF_BYTES  512   bytes per buffer; buffer B base = BUF_BYTES
//  MAX_LEN    510   largest legal payload length (BUF_BYTES-2)
// PORTS
//  Clk          in   1       system clock
//  Rst          in   1       reset: asynchronous, active-high
//  Tx_Req_A     in   1       level, buffer A start flag from glue
//  Tx_Req_B     in   1       level, buffer B start flag from glue
//  Tx_Finish_A  out  1       1-cycle pulse: frame A fully accepted downstream
//  Tx_Finish_B  out  1       1-cycle pulse: frame B fully accepted downstream
//  Ram_RA       out  ADDR_W  TX RAM read byte address
//  Ram_REN      out  1       TX RAM read enable; Ram_RD valid exactly 1 cycle later
//  Ram_RD       in   8       TX RAM read data
//  Out_Data     out  8       payload byte
//  Out_Valid    out  1       Out_Data valid; held until Out_Ready
//  Out_Ready    in   1       encoder accepts byte when Out_Valid&Out_Ready
//  Out_Sof      out  1       qualifies first payload byte
//  Out_Eof      out  1       qualifies last payload byte
//  Busy         out  1       high in any state except IDLE
//  Active_Buf   out  1       0=A, 1=B; buffer currently served
//  Len_Err      out  1       1-cycle pulse: header length > MAX_LEN, clamped
// BEHAVIOUR
//  Reset: every output 0; FSM=IDLE; rr pointer=B (A wins first tie); arm_A=arm_B=1.
//  Eligibility: buffer X is eligible when Tx_Req_X=1 and arm_X=1.
//   arm_X clears on grant to X and sets again once Tx_Req_X is sampled 0.
//   Purpose: the still-high glue flag in the cycle after the finish pulse must not retrigger a send.
//  Arbitration (IDLE only): one eligible buffer -> grant it; both eligible -> grant the one not last served; update pointer on grant.
//  FSM (one state per cycle unless noted):
//   IDLE    : grant -> HDR0
//   HDR0    : Ram_REN=1, RA=base -> HDR1
//   HDR1    : len[15:8]<=Ram_RD; Ram_REN=1, RA=base+1 -> LEN
//   LEN     : len[7:0]<=Ram_RD; len>MAX_LEN -> len=MAX_LEN and pulse Len_Err; idx<=0
//             len==0 -> FIN; else -> DRD
//   DRD     : Ram_REN=1, RA=base+2+idx -> DWT
//   DWT     : Out_Data<=Ram_RD, Out_Valid=1 held (data stable) until accepted
//             Sof=(idx==0), Eof=(idx==len-1); on accept: idx+1, Eof ? FIN : DRD
//   FIN     : Tx_Finish_X=1 for exactly this cycle -> IDLE
//  Latency: grant edge -> first Out_Valid after 4 cycles; throughput max 1 byte per 2 Clk.
//  Widths: len,idx 16-bit unsigned; address base+2+idx computed in ADDR_W bits, never wraps (idx<=509).
//  Ram_REN low in all states except HDR0/HDR1/DRD.
//  Request dropped mid-frame: ignored; frame completes, finish still pulses.
//  Out_Ready stuck low: stall indefinitely in DWT, no timeout.
//  Rst mid-frame: immediate abort; no finish pulse; partial frame discarded downstream.
//  Len_Err and Tx_Finish never coincide (LEN vs FIN).
// STRUCTURE
//  Package ttc_tx_pkg: FSM state enum (IDLE,HDR0,HDR1,LEN,DRD,DWT,FIN), BUF_A_BASE=0, BUF_B_BASE=512, HDR_BYTES=2.
//  Sub-module rr_arb2: 2-way round-robin arbiter with pointer register and grant-enable input, shared with future RX-side scheduling.
// TESTING
//  A only: RAM[0..1]=00 03, RAM[2..4]=AA BB CC; Tx_Req_A=1, Out_Ready=1
//   -> Out AA(Sof) BB CC(Eof) at 2-cycle spacing; Tx_Finish_A 1 cycle; no resend while Tx_Req_A still high.
//  A and B raised same cycle after reset -> A frame streamed fully, then B; second simultaneous request -> B first (pointer alternates).
//  B header 00 00 -> no Out_Valid; Tx_Finish_B pulses 4 cycles after grant.
//  Header FF FF in A -> Len_Err pulse; exactly 510 bytes from RAM[2..511]; last RA=511, never touches B region.
//  Out_Ready held 0 for 20 cycles mid-frame -> Out_Data/Eof/Sof stable; resumes with no byte lost or duplicated.
//  Rst asserted during DWT of byte 5 -> all outputs 0 asynchronously; no finish pulse; next Tx_Req_A restarts from header.

Source files
------------

// File: rtl/ttc_tx_pkg.sv
// Shared TX scheduler types: FSM states and TX RAM buffer layout.
// No logic; latency and backpressure are not applicable.
package ttc_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR0,
    HDR1,
    LEN,
    DRD,
    DWT,
    FIN
  } tx_state_e;

  localparam int BUF_A_BASE = 0;
  localparam int BUF_B_BASE = 512;
  localparam int HDR_BYTES  = 2;

endpackage

// File: rtl/ttc_tx_frame_scheduler_rr_arb2.sv
// 2-way round-robin arbiter; the pointer remembers the last granted requester.
// Grant is combinational in the cycle en_i is high; no backpressure path.
module rr_arb2
  import ttc_tx_pkg::*;
(
  input  logic       Clk,
  input  logic       Rst,
  input  logic [1:0] req_i,
  input  logic       en_i,
  output logic [1:0] gnt_o
);

  logic last_q, last_d;  // 0: requester 0 served last, 1: requester 1

  always_comb begin
    gnt_o  = 2'b00;
    last_d = last_q;
    if (en_i) begin
      case (req_i)
        2'b01:   gnt_o = 2'b01;
        2'b10:   gnt_o = 2'b10;
        2'b11:   gnt_o = last_q ? 2'b01 : 2'b10;
        default: gnt_o = 2'b00;
      endcase
      if (gnt_o != 2'b00) last_d = gnt_o[1];
    end
  end

  // Pointer starts at requester 1 so requester 0 wins the first tie.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) last_q <= 1'b1;
    else     last_q <= last_d;
  end

endmodule

// File: rtl/ttc_tx_frame_scheduler.sv
// Drains TX frame buffers A/B from the TX RAM into the downlink encoder, one frame per grant.
// First byte 4 cycles after grant, 1 byte per 2 cycles; Out_Valid holds with stable data until Out_Ready.
module ttc_tx_frame_scheduler
  import ttc_tx_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int BUF_BYTES = BUF_B_BASE,
  parameter int MAX_LEN   = BUF_B_BASE - HDR_BYTES
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Tx_Req_A,
  input  logic              Tx_Req_B,
  output logic              Tx_Finish_A,
  output logic              Tx_Finish_B,
  output logic [ADDR_W-1:0] Ram_RA,
  output logic              Ram_REN,
  input  logic [7:0]        Ram_RD,
  output logic [7:0]        Out_Data,
  output logic              Out_Valid,
  input  logic              Out_Ready,
  output logic              Out_Sof,
  output logic              Out_Eof,
  output logic              Busy,
  output logic              Active_Buf,
  output logic              Len_Err
);

  tx_state_e         state_q, state_d;
  logic              buf_q, buf_d;
  logic [15:0]       len_q, len_d;
  logic [15:0]       idx_q, idx_d;
  logic [7:0]        hold_q, hold_d;
  logic              first_q, first_d;
  logic              arm_a_q, arm_a_d;
  logic              arm_b_q, arm_b_d;
  logic [1:0]        gnt;
  logic [15:0]       len_raw;
  logic [7:0]        dwt_byte;
  logic [ADDR_W-1:0] base;

  rr_arb2 u_arb (
    .Clk   (Clk),
    .Rst   (Rst),
    .req_i ({Tx_Req_B & arm_b_q, Tx_Req_A & arm_a_q}),
    .en_i  (state_q == IDLE),
    .gnt_o (gnt)
  );

  assign base     = buf_q ? ADDR_W'(BUF_BYTES) : ADDR_W'(BUF_A_BASE);
  assign len_raw  = {len_q[15:8], Ram_RD};
  // Ram_RD is only live in the first DWT cycle; later stall cycles replay the held copy.
  assign dwt_byte = first_q ? Ram_RD : hold_q;

  always_comb begin
    state_d     = state_q;
    buf_d       = buf_q;
    len_d       = len_q;
    idx_d       = idx_q;
    hold_d      = hold_q;
    first_d     = 1'b0;
    arm_a_d     = arm_a_q | ~Tx_Req_A;
    arm_b_d     = arm_b_q | ~Tx_Req_B;
    Ram_REN     = 1'b0;
    Ram_RA      = '0;
    Out_Data    = 8'h00;
    Out_Valid   = 1'b0;
    Out_Sof     = 1'b0;
    Out_Eof     = 1'b0;
    Len_Err     = 1'b0;
    Tx_Finish_A = 1'b0;
    Tx_Finish_B = 1'b0;
    if (gnt[0]) arm_a_d = 1'b0;
    if (gnt[1]) arm_b_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (gnt != 2'b00) begin
          buf_d   = gnt[1];
          state_d = HDR0;
        end
      end
      HDR0: begin
        Ram_REN = 1'b1;
        Ram_RA  = base;
        state_d = HDR1;
      end
      HDR1: begin
        Ram_REN = 1'b1;
        Ram_RA  = base + ADDR_W'(1);
        len_d   = {Ram_RD, 8'h00};
        state_d = LEN;
      end
      LEN: begin
        idx_d = 16'd0;
        if (len_raw > 16'(MAX_LEN)) begin
          len_d   = 16'(MAX_LEN);
          Len_Err = 1'b1;
        end else begin
          len_d = len_raw;
        end
        state_d = (len_raw == 16'd0) ? FIN : DRD;
      end
      DRD: begin
        Ram_REN = 1'b1;
        Ram_RA  = base + ADDR_W'(HDR_BYTES) + idx_q[ADDR_W-1:0];
        first_d = 1'b1;
        state_d = DWT;
      end
      DWT: begin
        Out_Valid = 1'b1;
        Out_Data  = dwt_byte;
        hold_d    = dwt_byte;
        Out_Sof   = (idx_q == 16'd0);
        Out_Eof   = (idx_q == len_q - 16'd1);
        if (Out_Ready) begin
          idx_d   = idx_q + 16'd1;
          state_d = Out_Eof ? FIN : DRD;
        end
      end
      FIN: begin
        Tx_Finish_A = ~buf_q;
        Tx_Finish_B = buf_q;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= IDLE;
      buf_q   <= 1'b0;
      len_q   <= 16'd0;
      idx_q   <= 16'd0;
      hold_q  <= 8'h00;
      first_q <= 1'b0;
      arm_a_q <= 1'b1;
      arm_b_q <= 1'b1;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
      first_q <= first_d;
      arm_a_q <= arm_a_d;
      arm_b_q <= arm_b_d;
    end
  end

  assign Busy       = (state_q != IDLE);
  assign Active_Buf = buf_q;

endmodule

// File: tb/tb_ttc_tx_frame_scheduler.sv
// Directed bench for ttc_tx_frame_scheduler with a synchronous TX RAM model and a byte/finish scoreboard.
// Outputs are sampled on the falling edge; Out_Ready is driven at the same falling edge it is sampled.
module tb_ttc_tx_frame_scheduler;

  logic       Clk = 1'b0;
  logic       Rst;
  logic       Tx_Req_A, Tx_Req_B;
  logic       Tx_Finish_A, Tx_Finish_B;
  logic [9:0] Ram_RA;
  logic       Ram_REN;
  logic [7:0] Ram_RD = 8'h00;
  logic [7:0] Out_Data;
  logic       Out_Valid, Out_Ready, Out_Sof, Out_Eof;
  logic       Busy, Active_Buf, Len_Err;

  always #5 Clk = ~Clk;

  ttc_tx_frame_scheduler dut (
    .Clk         (Clk),
    .Rst         (Rst),
    .Tx_Req_A    (Tx_Req_A),
    .Tx_Req_B    (Tx_Req_B),
    .Tx_Finish_A (Tx_Finish_A),
    .Tx_Finish_B (Tx_Finish_B),
    .Ram_RA      (Ram_RA),
    .Ram_REN     (Ram_REN),
    .Ram_RD      (Ram_RD),
    .Out_Data    (Out_Data),
    .Out_Valid   (Out_Valid),
    .Out_Ready   (Out_Ready),
    .Out_Sof     (Out_Sof),
    .Out_Eof     (Out_Eof),
    .Busy        (Busy),
    .Active_Buf  (Active_Buf),
    .Len_Err     (Len_Err)
  );

  logic [7:0] mem [0:1023];
  always @(posedge Clk) if (Ram_REN) Ram_RD <= mem[Ram_RA];

  typedef struct {
    logic [7:0] d;
    logic       sof;
    logic       eof;
  } beat_t;

  beat_t exp_q[$];
  bit    fin_q[$];

  int errors = 0;
  int checks = 0;
  int cyc, first_vld, last_acc, fin_cyc, lenerr_cnt, max_ra, last_ra, acc_cnt;
  bit chk_spacing, prev_stall;
  logic [7:0] prev_d;
  logic prev_sof, prev_eof;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic new_test();
    cyc = 0; first_vld = -1; last_acc = -1; fin_cyc = -1; lenerr_cnt = 0;
    max_ra = 0; last_ra = -1; acc_cnt = 0; chk_spacing = 0; prev_stall = 0;
  endtask

  task automatic load_frame(input int base, input int hdr, input int n, input logic [7:0] seed);
    mem[base]     = 8'(hdr >> 8);
    mem[base + 1] = 8'(hdr);
    for (int i = 0; i < n; i++) mem[base + 2 + i] = seed + 8'(i * 37);
  endtask

  task automatic expect_frame(input bit b, input int n);
    int base;
    beat_t bt;
    base = b ? 512 : 0;
    for (int i = 0; i < n; i++) begin
      bt.d = mem[base + 2 + i]; bt.sof = (i == 0); bt.eof = (i == n - 1);
      exp_q.push_back(bt);
    end
    fin_q.push_back(b);
  endtask

  task automatic step(input bit rdy);
    beat_t bt;
    bit    f;
    @(negedge Clk);
    Out_Ready = rdy;
    cyc++;
    if (prev_stall) begin
      chk("stall_valid", 32'(Out_Valid), 32'd1);
      chk("stall_data", 32'(Out_Data), 32'(prev_d));
      chk("stall_sof", 32'(Out_Sof), 32'(prev_sof));
      chk("stall_eof", 32'(Out_Eof), 32'(prev_eof));
    end
    if (Out_Valid && first_vld < 0) first_vld = cyc;
    if (Out_Valid && Out_Ready) begin
      if (exp_q.size() == 0) chk("unexpected_byte", 32'(exp_q.size()), 32'd1);
      else begin
        bt = exp_q.pop_front();
        chk("byte_data", 32'(Out_Data), 32'(bt.d));
        chk("byte_sof", 32'(Out_Sof), 32'(bt.sof));
        chk("byte_eof", 32'(Out_Eof), 32'(bt.eof));
      end
      if (chk_spacing && last_acc >= 0) chk("byte_spacing", cyc - last_acc, 2);
      last_acc = cyc;
      acc_cnt++;
    end
    prev_stall = Out_Valid && !Out_Ready;
    prev_d = Out_Data; prev_sof = Out_Sof; prev_eof = Out_Eof;
    if (Ram_REN) begin
      last_ra = int'(Ram_RA);
      if (int'(Ram_RA) > max_ra) max_ra = int'(Ram_RA);
    end
    if (Len_Err) lenerr_cnt++;
    if (Tx_Finish_A || Tx_Finish_B) begin
      chk("fin_vs_lenerr", 32'(Len_Err), 32'd0);
      if (fin_q.size() == 0) chk("unexpected_finish", 32'(fin_q.size()), 32'd1);
      else begin
        f = fin_q.pop_front();
        chk("fin_b", 32'(Tx_Finish_B), 32'(f));
        chk("fin_a", 32'(Tx_Finish_A), 32'(!f));
      end
      fin_cyc = cyc;
    end
  endtask

  task automatic run(input int max);
    int n;
    n = 0;
    while ((fin_q.size() != 0 || exp_q.size() != 0) && n < max) begin
      step(1'b1);
      n++;
    end
    chk("drain_finishes", 32'(fin_q.size()), 32'd0);
    chk("drain_bytes", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_fin_a"}, 32'(Tx_Finish_A), 32'd0);
    chk({tag, "_fin_b"}, 32'(Tx_Finish_B), 32'd0);
    chk({tag, "_ram_ra"}, 32'(Ram_RA), 32'd0);
    chk({tag, "_ram_ren"}, 32'(Ram_REN), 32'd0);
    chk({tag, "_out_data"}, 32'(Out_Data), 32'd0);
    chk({tag, "_out_valid"}, 32'(Out_Valid), 32'd0);
    chk({tag, "_sof"}, 32'(Out_Sof), 32'd0);
    chk({tag, "_eof"}, 32'(Out_Eof), 32'd0);
    chk({tag, "_busy"}, 32'(Busy), 32'd0);
    chk({tag, "_active_buf"}, 32'(Active_Buf), 32'd0);
    chk({tag, "_len_err"}, 32'(Len_Err), 32'd0);
  endtask

  task automatic do_reset();
    Rst = 1'b1;
    prev_stall = 0;
    repeat (3) @(negedge Clk);
    chk_all_zero("reset");
    Rst = 1'b0;
  endtask

  initial begin
    int n;
    Rst = 1'b1; Tx_Req_A = 1'b0; Tx_Req_B = 1'b0; Out_Ready = 1'b0;
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    do_reset();

    // A only: 00 03 AA BB CC
    mem[0] = 8'h00; mem[1] = 8'h03; mem[2] = 8'hAA; mem[3] = 8'hBB; mem[4] = 8'hCC;
    new_test(); chk_spacing = 1;
    expect_frame(1'b0, 3);
    Tx_Req_A = 1'b1;
    run(100);
    chk("a_first_valid_cycle", first_vld, 5);
    chk("a_finish_cycle", fin_cyc, 10);
    repeat (10) step(1'b1);
    chk("a_no_resend_busy", 32'(Busy), 32'd0);
    Tx_Req_A = 1'b0;
    repeat (2) step(1'b1);

    // Tie after A was served last: B goes first
    load_frame(0, 4, 4, 8'h10);
    load_frame(512, 5, 5, 8'h50);
    new_test();
    expect_frame(1'b1, 5);
    expect_frame(1'b0, 4);
    Tx_Req_A = 1'b1; Tx_Req_B = 1'b1;
    run(200);
    Tx_Req_A = 1'b0; Tx_Req_B = 1'b0;
    repeat (2) step(1'b1);
    chk("tie2_last_buf_a", 32'(Active_Buf), 32'd0);

    // Tie straight after reset: A goes first
    do_reset();
    load_frame(0, 6, 6, 8'h21);
    load_frame(512, 2, 2, 8'h77);
    new_test();
    expect_frame(1'b0, 6);
    expect_frame(1'b1, 2);
    Tx_Req_A = 1'b1; Tx_Req_B = 1'b1;
    run(200);
    Tx_Req_A = 1'b0; Tx_Req_B = 1'b0;
    repeat (2) step(1'b1);
    chk("tie1_last_buf_b", 32'(Active_Buf), 32'd1);

    // B zero-length header
    mem[512] = 8'h00; mem[513] = 8'h00;
    new_test();
    fin_q.push_back(1'b1);
    Tx_Req_B = 1'b1;
    run(50);
    chk("zero_len_finish_cycle", fin_cyc, 4);
    chk("zero_len_no_valid", first_vld, -1);
    Tx_Req_B = 1'b0;
    repeat (2) step(1'b1);

    // Oversize header clamps to 510 bytes, stays inside buffer A
    load_frame(0, 16'hFFFF, 510, 8'h03);
    load_frame(512, 3, 3, 8'hE0);
    new_test();
    expect_frame(1'b0, 510);
    Tx_Req_A = 1'b1;
    run(2000);
    Tx_Req_A = 1'b0;
    chk("clamp_len_err_pulses", lenerr_cnt, 1);
    chk("clamp_max_ra", max_ra, 511);
    chk("clamp_last_ra", last_ra, 511);
    repeat (2) step(1'b1);

    // 20-cycle Out_Ready stall mid-frame
    load_frame(0, 10, 10, 8'h41);
    new_test();
    expect_frame(1'b0, 10);
    Tx_Req_A = 1'b1;
    n = 0;
    while (acc_cnt < 3 && n < 100) begin step(1'b1); n++; end
    chk("stall_reach_byte3", acc_cnt, 3);
    repeat (20) step(1'b0);
    chk("stall_valid_held", 32'(Out_Valid), 32'd1);
    run(200);
    Tx_Req_A = 1'b0;
    repeat (2) step(1'b1);

    // Reset while byte 5 is presented
    load_frame(0, 10, 10, 8'h92);
    new_test();
    expect_frame(1'b0, 10);
    Tx_Req_A = 1'b1;
    n = 0;
    while (acc_cnt < 4 && n < 100) begin step(1'b1); n++; end
    n = 0;
    while (!Out_Valid && n < 10) begin step(1'b0); n++; end
    chk("arst_in_byte5", 32'(Out_Valid), 32'd1);
    #2 Rst = 1'b1;
    #1 chk_all_zero("arst");
    exp_q.delete();
    fin_q.delete();
    prev_stall = 0;
    @(negedge Clk);
    Rst = 1'b0;
    new_test();
    expect_frame(1'b0, 10);
    run(200);
    chk("restart_first_valid_cycle", first_vld, 5);
    Tx_Req_A = 1'b0;
    repeat (2) step(1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
